uart_rx_io: RTL and testbench

Memory-mapped UART receiver on the processor's IO bus. It is the input-side counterpart of the LED output driver: it deserialises 8N1 frames from an external `rx` pin, buffers the received bytes in a small FIFO and returns them to load instructions that address the IO region. Reads are combinational so they fit the single-cycle datapath. A read of the DATA register pops the FIFO at the clock edge that completes the load.

---
 rtl/uart_rx_io.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_io.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_io.sv
// uart_rx_io: memory-mapped 8N1 UART receiver with a small byte FIFO.
// Loads to IO space read DATA (pops the FIFO) or STATUS (clears the sticky
// error flags). Read data is combinational so it fits a single-cycle datapath.
module uart_rx_io #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [31:0] addr,
  input  logic        isIO,
  input  logic        rdEn,
  output logic [31:0] rdata,
  output logic        rxPending
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLK_DIV);

  localparam logic [BaudW-1:0] HalfLast = BaudW'(CLK_DIV / 2 - 1);
  localparam logic [BaudW-1:0] BitLast  = BaudW'(CLK_DIV - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHi
  } rx_state_e;

  // Synchroniser
  logic rx_meta_q, rxs;

  // Receive FSM
  rx_state_e        state_q;
  logic [BaudW-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;

  // FIFO
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            overrun_q, frame_err_q;

  // Bus decode and events
  logic       sel, empty, full, pop, push, push_ok, status_rd;
  logic       stop_done, overrun_evt, frame_err_evt;
  logic [1:0] offset;
  logic [7:0] count8;

  logic unused_addr;
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  assign sel       = isIO & rdEn;
  assign offset    = addr[3:2];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CntFull);
  assign pop       = sel && (offset == 2'd0) && !empty;
  assign status_rd = sel && (offset == 2'd1);

  // The stop bit is sampled on the last cycle of the stop slot; the push and
  // the framing-error event both fire on that same edge.
  assign stop_done     = (state_q == StStop) && (baud_q == BitLast);
  assign push          = stop_done & rxs;
  assign frame_err_evt = stop_done & ~rxs;

  // A simultaneous pop makes room, so a push into a full FIFO still lands.
  assign push_ok     = push && (!full || pop);
  assign overrun_evt = push && full && !pop;

  // Two-flop synchroniser; idles high like the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs       <= rx_meta_q;
    end
  end

  // Receive FSM: start-bit qualify at half bit, then full-bit sampling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!rxs) begin
            state_q <= StStart;
            baud_q  <= '0;
            bit_q   <= '0;
          end
        end
        StStart: begin
          if (baud_q == HalfLast) begin
            baud_q  <= '0;
            // A line that is high again at mid start bit was a glitch.
            state_q <= rxs ? StIdle : StData;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StData: begin
          if (baud_q == BitLast) begin
            baud_q  <= '0;
            shift_q <= {rxs, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StStop: begin
          if (baud_q == BitLast) begin
            baud_q  <= '0;
            // Bad stop bit: wait for the line to recover so a break does not
            // look like a stream of new frames.
            state_q <= rxs ? StIdle : StWaitHi;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StWaitHi: begin
          if (rxs) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Next FIFO occupancy.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q] <= shift_q;
    end
  end

  // FIFO pointers, occupancy, pending flag and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rxPending   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q   <= count_d;
      rxPending <= (count_d != '0);
      // New events win over a clearing STATUS read on the same edge.
      overrun_q   <= (overrun_q & ~status_rd) | overrun_evt;
      frame_err_q <= (frame_err_q & ~status_rd) | frame_err_evt;
    end
  end

  assign count8 = 8'(count_q);

  // Combinational register read.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (offset)
        2'd0: begin
          if (!empty) begin
            rdata = {24'h0, mem[rptr_q]};
          end
        end
        2'd1:    rdata = {16'h0, count8, 5'h0, frame_err_q, overrun_q, ~empty};
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_io.sv
// Self-checking bench for uart_rx_io: serial frames are driven on rx, expected
// bytes are queued as frames complete and compared on DATA reads.
module tb_uart_rx_io;

  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [31:0] addr;
  logic        isIO;
  logic        rdEn;
  logic [31:0] rdata;
  logic        rxPending;

  uart_rx_io #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .addr     (addr),
    .isIO     (isIO),
    .rdEn     (rdEn),
    .rdata    (rdata),
    .rxPending(rxPending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // First negedge at which rxPending is seen high after being low.
  int   rise_cyc = -1;
  logic pend_prev = 1'b0;
  always @(negedge clk) begin
    if (rxPending && !pend_prev) rise_cyc = cyc;
    pend_prev = rxPending;
  end

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Entered and left on a negedge; holds the load for exactly one cycle.
  task automatic read_reg(input logic [1:0] off, output logic [31:0] val);
    addr = {28'h0, off, 2'b00};
    isIO = 1'b1;
    rdEn = 1'b1;
    #1 val = rdata;
    @(negedge clk);
    isIO = 1'b0;
    rdEn = 1'b0;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] v;
    logic [31:0] e;
    read_reg(2'd0, v);
    e = (exp_q.size() != 0) ? {24'h0, exp_q.pop_front()} : 32'h0;
    check(tag, v, e);
  endtask

  task automatic read_status(input string tag);
    logic [31:0] v;
    logic [31:0] e;
    e = {16'h0, 8'(exp_q.size()), 5'h0, m_ferr, m_ovr, exp_q.size() != 0};
    read_reg(2'd1, v);
    check(tag, v, e);
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  // Drives the first nslots of {stop, data[7:0], start}, LSB first.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int nslots);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < nslots; i++) begin
      rx = fr[i];
      repeat (CLK_DIV) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_frame(b, stop_bit, 10);
    if (stop_bit) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  initial begin
    int n;
    reset = 1'b0;
    rx    = 1'b1;
    addr  = '0;
    isIO  = 1'b0;
    rdEn  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pend", {31'h0, rxPending}, 32'h0);
    read_status("rst_status");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single byte, pending latency, pop clears pending
    n = cyc;
    rise_cyc = -1;
    send_byte(8'hA5, 1'b1);
    check("t1_rise", 32'(rise_cyc - n), 32'(2 + CLK_DIV / 2 + 9 * CLK_DIV + 1));
    addr = '0;
    isIO = 1'b1;
    rdEn = 1'b0;
    #1 check("t1_nosel", rdata, 32'h0);
    @(negedge clk);
    isIO = 1'b0;
    read_data("t1_data");
    check("t1_pend_after", {31'h0, rxPending}, 32'h0);

    // 2: back-to-back frames, ordered reads, read of empty
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    read_status("t2_status");
    for (int i = 0; i < 4; i++) read_data("t2_data");
    read_status("t2_status_empty");

    // 3: overrun on the fifth byte, cleared by STATUS read
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b1);
    read_status("t3_status_ovr");
    for (int i = 0; i < 4; i++) read_data("t3_data");
    read_status("t3_status_clr");

    // 4: pop aligned with the stop-sample edge of a push into a full FIFO
    for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 1'b1);
    fork
      send_byte(8'h55, 1'b1);
      begin
        repeat (2 + CLK_DIV / 2 + 9 * CLK_DIV) @(negedge clk);
        read_data("t4_aligned");
      end
    join
    read_status("t4_status");
    for (int i = 0; i < 4; i++) read_data("t4_data");

    // 5: framing error followed by a long break, then a good frame
    send_byte(8'hC3, 1'b0);
    repeat (40 * CLK_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    read_status("t5_status_ferr");
    send_byte(8'h3C, 1'b1);
    read_status("t5_status_ok");
    read_data("t5_data");

    // 6: glitch, then asynchronous reset in the middle of a frame
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    check("t6_glitch_pend", {31'h0, rxPending}, 32'h0);
    read_status("t6_glitch_status");
    send_byte(8'h11, 1'b1);
    check("t6_pend_before", {31'h0, rxPending}, 32'h1);
    drive_frame(8'h7E, 1'b1, 5);
    repeat (CLK_DIV / 2) @(negedge clk);
    reset = 1'b0;
    #1 check("t6_rst_pend", {31'h0, rxPending}, 32'h0);
    exp_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    rx     = 1'b1;
    @(negedge clk);
    read_status("t6_rst_status");
    read_data("t6_rst_data");
    reset = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h7E, 1'b1);
    read_status("t6_status");
    read_data("t6_data");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
